cam_scramble_tx: RTL and testbench

Transmit-side companion of the slave descrambler. It captures the camera's 8-bit RGB444 byte stream, packs each byte pair into a 12-bit pixel and XORs it with a 12-bit LFSR keystream. It forwards href/vsync and emits a per-frame resync strobe so the slave reloads its LFSR from the same code. It sits between the camera pins and the inter-board link; its outputs feed the slave's `data`, `i_href`, `i_vsync`, `reset_c` and `code`.

---
 rtl/cam_scramble_pkg.sv | 19 +
 rtl/lfsr12_gen.sv | 26 ++
 rtl/cam_scramble_tx.sv | 180 ++++++++++++++++++
 tb/tb_cam_scramble_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_scramble_pkg.sv
// Shared types and LFSR helpers for the camera scrambler and its slave descrambler.
package cam_scramble_pkg;

    typedef enum logic [1:0] {
        StWaitVs,
        StVblank,
        StResync,
        StActive
    } state_e;

    // Feedback taps l[11], l[5], l[3], l[0].
    localparam logic [11:0] LfsrTaps    = 12'h829;
    localparam logic [11:0] ZeroSeedSub = 12'h001;

    function automatic logic [11:0] lfsr_next(input logic [11:0] l);
        return {^(l & LfsrTaps), l[11:1]};
    endfunction

endpackage

// File: rtl/lfsr12_gen.sv
// 12-bit keystream LFSR; free-runs every clock except when a new seed is loaded.
module lfsr12_gen
    import cam_scramble_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] seed,
    output logic [11:0] key
);

    logic [11:0] key_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q <= ZeroSeedSub;
        end else if (load) begin
            key_q <= seed;
        end else begin
            key_q <= lfsr_next(key_q);
        end
    end

    assign key = key_q;

endmodule

// File: rtl/cam_scramble_tx.sv
// Camera RGB444 byte packer and LFSR scrambler with per-frame resync to the slave.
// Define CAM_SCRAMBLE_EN to XOR pixels with the keystream; otherwise plaintext is sent.
module cam_scramble_tx
    import cam_scramble_pkg::*;
#(
    parameter int unsigned H_PIXELS   = 320,
    parameter int unsigned V_LINES    = 240,
    parameter int unsigned RESYNC_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cam_data,
    input  logic        cam_href,
    input  logic        cam_vsync,
    input  logic [11:0] code,
    output logic [11:0] o_data,
    output logic        o_href,
    output logic        o_vsync,
    output logic        o_reset_c,
    output logic [11:0] o_code,
    output logic        o_pix_valid,
    output logic        o_line_err,
    output logic        o_frame_err
);

    localparam int unsigned ColW = $clog2(H_PIXELS + 2);
    localparam int unsigned RowW = $clog2(V_LINES + 2);
    localparam int unsigned RsW  = $clog2(RESYNC_LEN + 1);

    state_e          state_q, state_d;
    logic            vs1_q, vs2_q, href1_q, href2_q;
    logic            phase_q, phase_d;
    logic [3:0]      r_q, r_d;
    logic [11:0]     pix_q, pix_d;
    logic            pix_stb_q, pix_stb_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [RsW-1:0]  rs_cnt_q, rs_cnt_d;
    logic            line_err_q, line_err_d;
    logic            frame_err_q, frame_err_d;
    logic [11:0]     code_q, code_d;
    logic [11:0]     data_q, data_d;
    logic            valid_q, reset_c_q;
    logic            load, active, vs_rise, vs_fall, href_fall;
    logic [11:0]     key, keystream;

    lfsr12_gen u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .seed  (code_d),
        .key   (key)
    );

`ifdef CAM_SCRAMBLE_EN
    assign keystream = key;
`else
    logic unused_key;
    assign unused_key = ^key;
    assign keystream  = '0;
`endif

    // Vsync edges come from the delay line so o_reset_c lines up with o_vsync.
    assign vs_rise   = vs1_q & ~vs2_q;
    assign vs_fall   = vs2_q & ~vs1_q;
    assign href_fall = href1_q & ~cam_href;
    assign active    = (state_q == StActive);

    always_comb begin
        state_d     = state_q;
        phase_d     = 1'b0;
        r_d         = r_q;
        pix_d       = pix_q;
        pix_stb_d   = 1'b0;
        col_d       = '0;
        row_d       = row_q;
        rs_cnt_d    = rs_cnt_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        code_d      = code_q;
        load        = 1'b0;
        data_d      = '0;

        if (cam_href) begin
            phase_d = ~phase_q;
            col_d   = col_q;
            if (!phase_q) begin
                r_d = cam_data[3:0];
            end else if (active) begin
                pix_d     = {r_q, cam_data};
                pix_stb_d = 1'b1;
                if (col_q != '1) col_d = col_q + ColW'(1);
            end
        end

        // A trailing half pixel (phase still 1) also marks the line bad.
        if (href_fall && active) begin
            if (col_q != ColW'(H_PIXELS) || phase_q) line_err_d = 1'b1;
            if (row_q != '1) row_d = row_q + RowW'(1);
        end

        unique case (state_q)
            StWaitVs: if (vs1_q) state_d = StVblank;
            StVblank: begin
                if (vs_fall) begin
                    state_d  = StResync;
                    load     = 1'b1;
                    code_d   = (code == 12'h000) ? ZeroSeedSub : code;
                    rs_cnt_d = '0;
                    row_d    = '0;
                end
            end
            StResync: begin
                if (rs_cnt_q == RsW'(RESYNC_LEN - 1)) state_d = StActive;
                else rs_cnt_d = rs_cnt_q + RsW'(1);
            end
            StActive: begin
                if (vs_rise) begin
                    state_d = StVblank;
                    if (row_q != RowW'(V_LINES)) frame_err_d = 1'b1;
                end
            end
            default: state_d = StWaitVs;
        endcase

        if (href1_q) data_d = pix_stb_q ? (pix_q ^ keystream) : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StWaitVs;
            vs1_q       <= 1'b0;
            vs2_q       <= 1'b0;
            href1_q     <= 1'b0;
            href2_q     <= 1'b0;
            phase_q     <= 1'b0;
            r_q         <= '0;
            pix_q       <= '0;
            pix_stb_q   <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            rs_cnt_q    <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            code_q      <= ZeroSeedSub;
            data_q      <= '0;
            valid_q     <= 1'b0;
            reset_c_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs1_q       <= cam_vsync;
            vs2_q       <= vs1_q;
            href1_q     <= cam_href;
            href2_q     <= href1_q;
            phase_q     <= phase_d;
            r_q         <= r_d;
            pix_q       <= pix_d;
            pix_stb_q   <= pix_stb_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rs_cnt_q    <= rs_cnt_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            code_q      <= code_d;
            data_q      <= data_d;
            valid_q     <= pix_stb_q;
            reset_c_q   <= (state_d == StResync);
        end
    end

    assign o_data      = data_q;
    assign o_href      = href2_q;
    assign o_vsync     = vs2_q;
    assign o_reset_c   = reset_c_q;
    assign o_code      = code_q;
    assign o_pix_valid = valid_q;
    assign o_line_err  = line_err_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_cam_scramble_tx.sv
// Self-checking bench for cam_scramble_tx: vector table, random frames, error and resync corners.
module tb_cam_scramble_tx;

    localparam int unsigned HP = 320;
    localparam int unsigned VL = 12;
    localparam int unsigned RL = 4;
    localparam int          NV = 5;
`ifdef CAM_SCRAMBLE_EN
    localparam bit ScrEn = 1'b1;
`else
    localparam bit ScrEn = 1'b0;
`endif

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] plain;
    } vec_t;

    typedef struct {
        int          at;
        logic [11:0] plain;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cam_data;
    logic        cam_href, cam_vsync;
    logic [11:0] code;
    logic [11:0] o_data, o_code;
    logic        o_href, o_vsync, o_reset_c, o_pix_valid, o_line_err, o_frame_err;

    cam_scramble_tx #(
        .H_PIXELS   (HP),
        .V_LINES    (VL),
        .RESYNC_LEN (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cam_data    (cam_data),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .code        (code),
        .o_data      (o_data),
        .o_href      (o_href),
        .o_vsync     (o_vsync),
        .o_reset_c   (o_reset_c),
        .o_code      (o_code),
        .o_pix_valid (o_pix_valid),
        .o_line_err  (o_line_err),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          m_load = -100;
    logic [11:0] m_seed = 12'h001, m_key = 12'h001, m_kprev = 12'h001;
    int          rc_cnt = 0, rc_first = -1;
    logic [11:0] kobs [3];
    bit          kwatch = 0, zwatch = 0, sb_on = 0;
    int          kz = 0, nz = 0, sb_ok = 0, sb_bad = 0;
    exp_t        sb_q [$];
    vec_t        vecs [NV];

    // Slave-side keystream rule.
    function automatic logic [11:0] lfsr_step(input logic [11:0] l);
        return {l[11] ^ l[5] ^ l[3] ^ l[0], l[11:1]};
    endfunction

    function automatic logic [11:0] lfsr_prev(input logic [11:0] n);
        return {n[10:0], n[11] ^ n[10] ^ n[4] ^ n[2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        m_kprev = m_key;
        if (!reset) m_key = 12'h001;
        else if (cyc == m_load) m_key = m_seed;
        else m_key = lfsr_step(m_key);
        #1;
        if (o_reset_c) begin
            if (rc_cnt == 0) rc_first = cyc;
            rc_cnt++;
        end
        for (int i = 0; i < 3; i++) if (cyc == m_load + i) kobs[i] = dut.u_lfsr.key;
        if (kwatch && dut.u_lfsr.key == 12'h000) kz++;
        if (zwatch && o_data != 12'h000) nz++;
        if (sb_on) begin
            if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
                e = sb_q.pop_front();
                if (o_pix_valid && ((o_data ^ (ScrEn ? m_kprev : 12'h000)) == e.plain)) sb_ok++;
                else sb_bad++;
            end else if (o_pix_valid) begin
                sb_bad++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cam_href = 1'b0; cam_vsync = 1'b0; cam_data = 8'h00; code = 12'h000;
        repeat (3) tick();
        reset = 1'b1;
        sb_q.delete();
    endtask

    task automatic start_frame(input logic [11:0] seed);
        cam_vsync = 1'b1;
        code = seed;
        repeat (3) tick();
        cam_vsync = 1'b0;
        rc_cnt = 0;
        tick();
        m_load = cyc + 1;
        m_seed = (seed == 12'h000) ? 12'h001 : seed;
        chk("vsync_hold", o_vsync, 1);
        tick();
        chk("vsync_fall", o_vsync, 0);
        repeat (5) tick();
        chk("rc_len", rc_cnt, RL);
        chk("rc_start", rc_first, m_load);
        chk("code_latch", o_code, m_seed);
    endtask

    task automatic end_frame();
        cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_line(input int npix, input bit extra, input bit push);
        logic [7:0] b0, b1;
        cam_href = 1'b1;
        for (int p = 0; p < npix; p++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            cam_data = b0;
            tick();
            cam_data = b1;
            if (push) sb_q.push_back('{at: cyc + 2, plain: {b0[3:0], b1}});
            tick();
        end
        if (extra) begin
            cam_data = 8'($urandom);
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic full_frame(input logic [11:0] seed);
        sb_ok = 0; sb_bad = 0; sb_on = 1;
        start_frame(seed);
        for (int l = 0; l < int'(VL); l++) send_line(HP, 1'b0, 1'b1);
        end_frame();
        sb_on = 0;
        chk("frame_pix_ok", sb_ok, HP * VL);
        chk("frame_pix_bad", sb_bad, 0);
        chk("frame_line_err", o_line_err, 0);
        chk("frame_frame_err", o_frame_err, 0);
    endtask

    task automatic check_vec(input int i);
        chk("vec_valid", o_pix_valid, 1);
        chk("vec_href", o_href, 1);
        chk("vec_data", o_data, vecs[i].plain ^ (ScrEn ? m_kprev : 12'h000));
        if (i == 0) chk("abd_key001", o_data, ScrEn ? 12'hABD : 12'hABC);
    endtask

    initial begin
        logic [11:0] seed;
        vecs[0] = '{8'h0A, 8'hBC, 12'hABC};
        vecs[1] = '{8'h05, 8'h5A, 12'h55A};
        vecs[2] = '{8'hF3, 8'h21, 12'h321};
        vecs[3] = '{8'h7E, 8'h00, 12'hE00};
        vecs[4] = '{8'h00, 8'hFF, 12'h0FF};

        reset = 1'b1;
        cam_href = 1'b0; cam_vsync = 1'b0; cam_data = 8'h00; code = 12'h000;
        #2;
        do_reset();
        chk("rst_data", o_data, 0);
        chk("rst_href", o_href, 0);
        chk("rst_vsync", o_vsync, 0);
        chk("rst_reset_c", o_reset_c, 0);
        chk("rst_valid", o_pix_valid, 0);
        chk("rst_errs", {o_line_err, o_frame_err}, 0);
        chk("rst_code", o_code, 12'h001);

        // Seed 001: key sequence after load, then a clean full frame.
        full_frame(12'h001);
        chk("key_load0", kobs[0], 12'h001);
        chk("key_load1", kobs[1], 12'h800);
        chk("key_load2", kobs[2], 12'hC00);

        // Zero seed is substituted and the keystream never hits zero.
        kz = 0; kwatch = 1;
        full_frame(12'h000);
        kwatch = 0;
        chk("zero_seed_key_nz", kz, 0);

        // Vector table: seed chosen so the first pixel sees key 001 at output.
        seed = 12'h001;
        for (int i = 0; i < 7; i++) seed = lfsr_prev(seed);
        start_frame(seed);
        for (int i = 0; i < NV; i++) begin
            cam_href = 1'b1;
            cam_data = vecs[i].b0;
            tick();
            if (i > 0) check_vec(i - 1);
            cam_data = vecs[i].b1;
            tick();
            chk("vec_gap_valid", o_pix_valid, 0);
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick();
        check_vec(NV - 1);
        repeat (2) tick();
        chk("href_off", o_href, 0);
        chk("data_off", o_data, 0);
        chk("short_line_err", o_line_err, 1);
        end_frame();
        chk("short_frame_err", o_frame_err, 1);

        // href during vertical blanking yields no pixels and zero data.
        sb_ok = 0; sb_bad = 0; sb_on = 1; nz = 0; zwatch = 1;
        send_line(8, 1'b0, 1'b0);
        zwatch = 0; sb_on = 0;
        chk("blank_href_pix", sb_bad, 0);
        chk("blank_href_data", nz, 0);

        // Reset mid-frame clears sticky flags; data ignored until a vsync.
        do_reset();
        chk("rst2_line_err", o_line_err, 0);
        chk("rst2_frame_err", o_frame_err, 0);
        chk("rst2_code", o_code, 12'h001);
        sb_ok = 0; sb_bad = 0; sb_on = 1;
        send_line(16, 1'b0, 1'b0);
        chk("wait_vs_ignored", sb_bad, 0);

        // 319-pixel line, then 641 bytes with the odd byte dropped.
        seed = 12'($urandom_range(1, 4095));
        start_frame(seed);
        chk("pre_line_err", o_line_err, 0);
        send_line(HP - 1, 1'b0, 1'b1);
        chk("l319_err", o_line_err, 1);
        send_line(HP, 1'b1, 1'b1);
        sb_on = 0;
        chk("odd_line_pix_ok", sb_ok, 2 * HP - 1);
        chk("odd_line_pix_bad", sb_bad, 0);
        chk("odd_line_err", o_line_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
